// File: rtl/image_mem_writer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// image_mem_writer_if : byte-stream in, RAM write port and status out. Rev 1.0
// ---------------------------------------------------------------------------
interface image_mem_writer_if #(
   parameter int ADDR_W = 18
) ();
   logic              start;
   logic [7:0]        in_data;
   logic              in_valid;
   logic              in_ready;
   logic [ADDR_W-1:0] wraddress;
   logic [7:0]        data;
   logic              wren;
   logic              busy;
   logic              done;
   logic              error;
   logic [15:0]       img_width;
   logic [15:0]       img_height;

   modport master (
      output start, in_data, in_valid,
      input  in_ready, wraddress, data, wren, busy, done, error, img_width, img_height
   );

   modport slave (
      input  start, in_data, in_valid,
      output in_ready, wraddress, data, wren, busy, done, error, img_width, img_height
   );
endinterface
`default_nettype wire

// File: rtl/image_mem_writer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// image_mem_writer : writes a width/height header plus row-major grayscale
// pixels from a byte stream into frame RAM.                        Rev 1.0
// ---------------------------------------------------------------------------
module image_mem_writer #(
   parameter int unsigned BASE_ADDRESS = 'h10,
   parameter int unsigned MEM_DEPTH    = 262144,
   parameter int          ADDR_W       = 18
) (
   input  wire logic          clk,
   input  wire logic          rst,
   image_mem_writer_if.slave  bus
);
   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_W_HI   = 4'd1,
      S_W_LO   = 4'd2,
      S_H_HI   = 4'd3,
      S_H_LO   = 4'd4,
      S_CHECK  = 4'd5,
      S_PIXELS = 4'd6,
      S_DONE   = 4'd7,
      S_ERROR  = 4'd8
   } state_t;

   state_t            r_state;
   logic              r_in_ready;
   logic [ADDR_W-1:0] r_wraddress;
   logic [7:0]        r_data;
   logic              r_wren;
   logic              r_busy;
   logic              r_done;
   logic              r_error;
   logic [15:0]       r_img_width;
   logic [15:0]       r_img_height;
   logic [31:0]       r_pix_cnt;

   logic              w_xfer;
   logic [31:0]       w_count;
   logic [32:0]       w_end;
   logic              w_reject;
   logic              w_last;
   logic [ADDR_W-1:0] w_pix_addr;

   assign w_xfer     = bus.in_valid & r_in_ready;
   assign w_count    = {16'd0, r_img_width} * {16'd0, r_img_height};
   // 33-bit sum so a huge pixel count cannot wrap past the depth check
   assign w_end      = {1'b0, w_count} + 33'(BASE_ADDRESS);
   assign w_reject   = (w_count == 32'd0) || (w_end > 33'(MEM_DEPTH));
   assign w_last     = (r_pix_cnt == (w_count - 32'd1));
   assign w_pix_addr = ADDR_W'(BASE_ADDRESS) + r_pix_cnt[ADDR_W-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_in_ready   <= 1'b0;
         r_wraddress  <= '0;
         r_data       <= 8'd0;
         r_wren       <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_error      <= 1'b0;
         r_img_width  <= 16'd0;
         r_img_height <= 16'd0;
         r_pix_cnt    <= 32'd0;
      end else begin
         r_wren <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (bus.start) begin
                  r_state    <= S_W_HI;
                  r_busy     <= 1'b1;
                  r_done     <= 1'b0;
                  r_error    <= 1'b0;
                  r_in_ready <= 1'b1;
               end
            end
            S_W_HI: begin
               if (w_xfer) begin
                  r_wren            <= 1'b1;
                  r_wraddress       <= ADDR_W'(0);
                  r_data            <= bus.in_data;
                  r_img_width[15:8] <= bus.in_data;
                  r_state           <= S_W_LO;
               end
            end
            S_W_LO: begin
               if (w_xfer) begin
                  r_wren           <= 1'b1;
                  r_wraddress      <= ADDR_W'(1);
                  r_data           <= bus.in_data;
                  r_img_width[7:0] <= bus.in_data;
                  r_state          <= S_H_HI;
               end
            end
            S_H_HI: begin
               if (w_xfer) begin
                  r_wren             <= 1'b1;
                  r_wraddress        <= ADDR_W'(4);
                  r_data             <= bus.in_data;
                  r_img_height[15:8] <= bus.in_data;
                  r_state            <= S_H_LO;
               end
            end
            S_H_LO: begin
               if (w_xfer) begin
                  r_wren            <= 1'b1;
                  r_wraddress       <= ADDR_W'(5);
                  r_data            <= bus.in_data;
                  r_img_height[7:0] <= bus.in_data;
                  r_state           <= S_CHECK;
                  r_in_ready        <= 1'b0;
               end
            end
            S_CHECK: begin
               if (w_reject) begin
                  r_state <= S_ERROR;
                  r_busy  <= 1'b0;
                  r_error <= 1'b1;
               end else begin
                  r_state    <= S_PIXELS;
                  r_in_ready <= 1'b1;
                  r_pix_cnt  <= 32'd0;
               end
            end
            S_PIXELS: begin
               if (w_xfer) begin
                  r_wren      <= 1'b1;
                  r_wraddress <= w_pix_addr;
                  r_data      <= bus.in_data;
                  r_pix_cnt   <= r_pix_cnt + 32'd1;
                  if (w_last) begin
                     r_state    <= S_DONE;
                     r_busy     <= 1'b0;
                     r_done     <= 1'b1;
                     r_in_ready <= 1'b0;
                  end
               end
            end
            default: begin
               r_state    <= S_IDLE;
               r_in_ready <= 1'b0;
               r_busy     <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready   = r_in_ready;
   assign bus.wraddress  = r_wraddress;
   assign bus.data       = r_data;
   assign bus.wren       = r_wren;
   assign bus.busy       = r_busy;
   assign bus.done       = r_done;
   assign bus.error      = r_error;
   assign bus.img_width  = r_img_width;
   assign bus.img_height = r_img_height;
endmodule
`default_nettype wire

// File: tb/tb_image_mem_writer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_image_mem_writer : table, hand-written and random frame loads checked
// against a write-list model of the frame loader.                  Rev 1.0
// ---------------------------------------------------------------------------
module tb_image_mem_writer;
   localparam int ADDR_W = 18;
   localparam int BASE   = 16;
   localparam int DEPTH  = 262144;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   image_mem_writer_if #(.ADDR_W(ADDR_W)) bus ();

   image_mem_writer #(
      .BASE_ADDRESS(BASE),
      .MEM_DEPTH   (DEPTH),
      .ADDR_W      (ADDR_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct { int addr; int data; } wr_t;
   typedef struct { int w; int h; int gap; bit seq; bit exp_err; int exp_wr; } vec_t;

   wr_t  wq[$];
   wr_t  exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   vec_t vt[9];

   always @(negedge clk) begin
      if (bus.wren === 1'b1) wq.push_back('{int'(bus.wraddress), int'(bus.data)});
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_bytes(input logic [7:0] b[$], input int gap);
      int idx = 0;
      int cyc = 0;
      bit v, xfer;
      while (idx < b.size() && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         case (gap)
            0:       v = 1'b1;
            1:       v = cyc[0];
            default: v = 1'($urandom_range(0, 1));
         endcase
         bus.in_valid = v;
         bus.in_data  = b[idx];
         xfer = v && (bus.in_ready === 1'b1);
         @(posedge clk);
         if (xfer) idx++;
      end
      if (idx < b.size()) check("stream_timeout", 64'(idx), 64'(b.size()));
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic send_header(input int w, input int h, input int gap);
      logic [7:0] hdr[$];
      hdr = {8'(w >> 8), 8'(w), 8'(h >> 8), 8'(h)};
      push_bytes(hdr, gap);
   endtask

   task automatic compare_writes(input string tag);
      int n;
      check({tag, "_wr_count"}, 64'(wq.size()), 64'(exp_q.size()));
      n = (wq.size() < exp_q.size()) ? wq.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check({tag, "_wr_addr"}, 64'(wq[i].addr), 64'(exp_q[i].addr));
         check({tag, "_wr_data"}, 64'(wq[i].data), 64'(exp_q[i].data));
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"},  64'(bus.in_ready),   64'd0);
      check({tag, "_wraddress"}, 64'(bus.wraddress),  64'd0);
      check({tag, "_data"},      64'(bus.data),       64'd0);
      check({tag, "_wren"},      64'(bus.wren),       64'd0);
      check({tag, "_busy"},      64'(bus.busy),       64'd0);
      check({tag, "_done"},      64'(bus.done),       64'd0);
      check({tag, "_error"},     64'(bus.error),      64'd0);
      check({tag, "_width"},     64'(bus.img_width),  64'd0);
      check({tag, "_height"},    64'(bus.img_height), 64'd0);
   endtask

   // Model: header slots 0,1,4,5; pixels from BASE only if the frame fits.
   task automatic run_frame(input int w, input int h, input int gap, input bit seq, output bit ok);
      longint     count;
      logic [7:0] pix[$];
      wq.delete();
      exp_q.delete();
      pulse_start();
      check("start_busy",  64'(bus.busy),     64'd1);
      check("start_ready", 64'(bus.in_ready), 64'd1);
      check("start_done",  64'(bus.done),     64'd0);
      check("start_error", 64'(bus.error),    64'd0);
      count = longint'(w) * longint'(h);
      ok = (count != 0) && (BASE + count <= DEPTH);
      exp_q.push_back('{0, (w >> 8) & 255});
      exp_q.push_back('{1, w & 255});
      exp_q.push_back('{4, (h >> 8) & 255});
      exp_q.push_back('{5, h & 255});
      send_header(w, h, gap);
      if (ok) begin
         for (int i = 0; i < int'(count); i++) begin
            pix.push_back(seq ? 8'(16 + i) : 8'($urandom));
            exp_q.push_back('{BASE + i, int'(pix[i])});
         end
         push_bytes(pix, gap);
      end
      repeat (3) @(negedge clk);
      check("frame_done",     64'(bus.done),       64'(ok));
      check("frame_error",    64'(bus.error),      64'(!ok));
      check("frame_busy",     64'(bus.busy),       64'd0);
      check("frame_in_ready", 64'(bus.in_ready),   64'd0);
      check("frame_width",    64'(bus.img_width),  64'(w));
      check("frame_height",   64'(bus.img_height), 64'(h));
      compare_writes("frame");
   endtask

   task automatic accept_check(input int w, input int h);
      pulse_start();
      send_header(w, h, 0);
      repeat (2) @(negedge clk);
      check("big_busy",     64'(bus.busy),     64'd1);
      check("big_error",    64'(bus.error),    64'd0);
      check("big_in_ready", 64'(bus.in_ready), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      bit ok;
      vt[0] = '{2,     3,     0, 1'b1, 1'b0, 10};
      vt[1] = '{2,     3,     1, 1'b1, 1'b0, 10};
      vt[2] = '{0,     5,     0, 1'b0, 1'b1, 4};
      vt[3] = '{512,   512,   0, 1'b0, 1'b1, 4};
      vt[4] = '{1,     1,     2, 1'b0, 1'b0, 5};
      vt[5] = '{0,     0,     0, 1'b0, 1'b1, 4};
      vt[6] = '{7,     37447, 0, 1'b0, 1'b1, 4};
      vt[7] = '{65535, 65535, 0, 1'b0, 1'b1, 4};
      vt[8] = '{1,     7,     1, 1'b0, 1'b0, 11};

      rst = 1'b1;
      bus.start = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data = 8'd0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;

      // Bytes offered while idle must be refused
      bus.in_valid = 1'b1;
      repeat (3) @(negedge clk);
      bus.in_valid = 1'b0;
      check("idle_no_write", 64'(wq.size()), 64'd0);

      for (int i = 0; i < 9; i++) begin
         run_frame(vt[i].w, vt[i].h, vt[i].gap, vt[i].seq, ok);
         check("tbl_error",  64'(bus.error),   64'(vt[i].exp_err));
         check("tbl_done",   64'(bus.done),    64'(!vt[i].exp_err));
         check("tbl_writes", 64'(wq.size()),   64'(vt[i].exp_wr));
      end

      accept_check(16'h01FF, 16'h01FF);
      accept_check(16, 16383);

      // Reset in the middle of a 4x4 frame
      begin
         logic [7:0] p3[$];
         p3 = {8'hA1, 8'hA2, 8'hA3};
         pulse_start();
         send_header(4, 4, 0);
         push_bytes(p3, 0);
         rst = 1'b1;
         @(negedge clk);
         check_reset_outputs("midrst");
         rst = 1'b0;
         run_frame(4, 4, 0, 1'b0, ok);
      end

      // start pulse during pixels of a 2x2 frame is ignored
      begin
         logic [7:0] pa[$];
         logic [7:0] pb[$];
         pa = {8'h51, 8'h52};
         pb = {8'h53, 8'h54};
         wq.delete();
         pulse_start();
         send_header(2, 2, 0);
         push_bytes(pa, 0);
         pulse_start();
         check("restart_busy", 64'(bus.busy), 64'd1);
         push_bytes(pb, 0);
         repeat (3) @(negedge clk);
         check("restart_done",   64'(bus.done),  64'd1);
         check("restart_writes", 64'(wq.size()), 64'd8);
         if (wq.size() == 8) begin
            check("restart_last_addr", 64'(wq[7].addr), 64'h13);
            check("restart_last_data", 64'(wq[7].data), 64'h54);
         end
         bus.in_valid = 1'b1;
         repeat (3) @(negedge clk);
         bus.in_valid = 1'b0;
         check("done_no_accept", 64'(wq.size()), 64'd8);
      end

      for (int i = 0; i < 15; i++) begin
         run_frame(int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                   int'($urandom_range(0, 2)), 1'b0, ok);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
